// File: rtl/uart_bus_pkg.sv
// Shared constants and FSM encoding for the UART-driven bus master.
package uart_bus_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;

    localparam logic [BYTE_W-1:0] CMD_WRITE = 8'h57;
    localparam logic [BYTE_W-1:0] CMD_READ  = 8'h52;
    localparam logic [BYTE_W-1:0] RSP_ACK   = 8'h06;
    localparam logic [BYTE_W-1:0] RSP_NAK   = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_BUS  = 3'd3,
        ST_RESP = 3'd4
    } state_t;

endpackage

// File: rtl/ubm_shift32.sv
// Little-endian 32-bit word assembler/disassembler addressed by a 2-bit byte index.
module ubm_shift32
    import uart_bus_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              byte_en,
    input  logic [1:0]        idx,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic              word_en,
    input  logic [WORD_W-1:0] word_in,
    output logic [WORD_W-1:0] word,
    output logic [BYTE_W-1:0] byte_c
);

    // Whole-word load takes priority over a byte insert.
    always_ff @(posedge clk) begin
        if (reset) begin
            word <= '0;
        end else if (word_en) begin
            word <= word_in;
        end else if (byte_en) begin
            word[{idx, 3'b000} +: BYTE_W] <= byte_in;
        end
    end

    assign byte_c = word[{idx, 3'b000} +: BYTE_W];

endmodule

// File: rtl/uart_bus_master.sv
// UART-command driven single-word initiator on a valid/ready native memory bus.
module uart_bus_master
    import uart_bus_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd5_000_000,
    parameter logic [15:0] BUS_WAIT_MAX   = 16'd1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_ready,
    output logic        rx_read,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        tx_write,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        cpu_hold
);

    state_t      state, state_nxt;
    logic [1:0]  idx, idx_nxt;
    logic        is_write, is_write_nxt;
    logic        nak, nak_nxt;
    logic [31:0] tmo_cnt, tmo_nxt;
    logic [15:0] wait_cnt, wait_nxt;
    logic        rx_guard, tx_guard;

    logic        rx_read_nxt, tx_write_nxt, mem_valid_nxt, cpu_hold_nxt;
    logic [7:0]  tx_data_nxt;
    logic [3:0]  mem_wstrb_nxt;
    logic        addr_en, data_en, rdata_en;

    logic        take, tx_ok, tmo_hit, bus_expire, last_byte, resp_last;
    logic [7:0]  addr_byte, rdata_byte, unused_addr_byte, unused_wdata_byte;
    logic [31:0] unused_rdata_word;

    // The guards skip the cycle of each pulse and the one after, while the UART flags settle.
    assign take       = rx_ready && !rx_read && !rx_guard;
    assign tx_ok      = tx_ready && !tx_write && !tx_guard;
    assign tmo_hit    = (TIMEOUT_CYCLES != 32'd0) && (tmo_cnt >= TIMEOUT_CYCLES);
    assign bus_expire = (17'(wait_cnt) + 17'd1) >= 17'(BUS_WAIT_MAX);
    assign last_byte  = (idx == 2'd3);
    assign resp_last  = (nak || is_write) ? (idx == 2'd0) : last_byte;
    assign addr_byte  = (idx == 2'd0) ? (rx_data & 8'hFC) : rx_data;

    ubm_shift32 u_addr (
        .clk(clk), .reset(reset), .byte_en(addr_en), .idx(idx), .byte_in(addr_byte),
        .word_en(1'b0), .word_in(32'd0), .word(mem_addr), .byte_c(unused_addr_byte)
    );

    ubm_shift32 u_wdata (
        .clk(clk), .reset(reset), .byte_en(data_en), .idx(idx), .byte_in(rx_data),
        .word_en(1'b0), .word_in(32'd0), .word(mem_wdata), .byte_c(unused_wdata_byte)
    );

    ubm_shift32 u_rdata (
        .clk(clk), .reset(reset), .byte_en(1'b0), .idx(idx), .byte_in(8'd0),
        .word_en(rdata_en), .word_in(mem_rdata), .word(unused_rdata_word), .byte_c(rdata_byte)
    );

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            idx       <= '0;
            is_write  <= 1'b0;
            nak       <= 1'b0;
            tmo_cnt   <= '0;
            wait_cnt  <= '0;
            rx_guard  <= 1'b0;
            tx_guard  <= 1'b0;
            rx_read   <= 1'b0;
            tx_write  <= 1'b0;
            tx_data   <= '0;
            mem_valid <= 1'b0;
            mem_wstrb <= '0;
            cpu_hold  <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            is_write  <= is_write_nxt;
            nak       <= nak_nxt;
            tmo_cnt   <= tmo_nxt;
            wait_cnt  <= wait_nxt;
            rx_guard  <= rx_read;
            tx_guard  <= tx_write;
            rx_read   <= rx_read_nxt;
            tx_write  <= tx_write_nxt;
            tx_data   <= tx_data_nxt;
            mem_valid <= mem_valid_nxt;
            mem_wstrb <= mem_wstrb_nxt;
            cpu_hold  <= cpu_hold_nxt;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        is_write_nxt = is_write;
        nak_nxt      = nak;
        tmo_nxt      = '0;
        wait_nxt     = '0;
        case (state)
            ST_IDLE: begin
                if (take) begin
                    idx_nxt = 2'd0;
                    if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
                        is_write_nxt = (rx_data == CMD_WRITE);
                        nak_nxt      = 1'b0;
                        state_nxt    = ST_ADDR;
                    end else begin
                        is_write_nxt = 1'b0;
                        nak_nxt      = 1'b1;
                        state_nxt    = ST_RESP;
                    end
                end
            end
            ST_ADDR, ST_DATA: begin
                if (take) begin
                    if (last_byte) begin
                        idx_nxt   = 2'd0;
                        state_nxt = (state == ST_ADDR && is_write) ? ST_DATA : ST_BUS;
                    end else begin
                        idx_nxt = idx + 2'd1;
                    end
                end else if (tmo_hit) begin
                    idx_nxt   = 2'd0;
                    state_nxt = ST_IDLE;
                end else begin
                    tmo_nxt = (tmo_cnt == '1) ? tmo_cnt : tmo_cnt + 32'd1;
                end
            end
            ST_BUS: begin
                if (mem_ready) begin
                    idx_nxt   = 2'd0;
                    state_nxt = ST_RESP;
                end else if (bus_expire) begin
                    idx_nxt   = 2'd0;
                    nak_nxt   = 1'b1;
                    state_nxt = ST_RESP;
                end else begin
                    wait_nxt = (wait_cnt == '1) ? wait_cnt : wait_cnt + 16'd1;
                end
            end
            ST_RESP: begin
                if (tx_ok) begin
                    if (resp_last) begin
                        idx_nxt   = 2'd0;
                        state_nxt = ST_IDLE;
                    end else begin
                        idx_nxt = idx + 2'd1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output pulses, bus request and shift-register strobes.
    always_comb begin
        rx_read_nxt   = 1'b0;
        tx_write_nxt  = 1'b0;
        tx_data_nxt   = tx_data;
        mem_valid_nxt = 1'b0;
        mem_wstrb_nxt = 4'h0;
        addr_en       = 1'b0;
        data_en       = 1'b0;
        rdata_en      = 1'b0;
        cpu_hold_nxt  = (state_nxt != ST_IDLE);
        case (state)
            ST_IDLE: rx_read_nxt = take;
            ST_ADDR: begin
                if (take) begin
                    rx_read_nxt   = 1'b1;
                    addr_en       = 1'b1;
                    mem_valid_nxt = last_byte && !is_write;
                end
            end
            ST_DATA: begin
                if (take) begin
                    rx_read_nxt = 1'b1;
                    data_en     = 1'b1;
                    if (last_byte) begin
                        mem_valid_nxt = 1'b1;
                        mem_wstrb_nxt = 4'hF;
                    end
                end
            end
            ST_BUS: begin
                rdata_en = mem_ready && !is_write;
                if (!mem_ready && !bus_expire) begin
                    mem_valid_nxt = 1'b1;
                    mem_wstrb_nxt = mem_wstrb;
                end
            end
            ST_RESP: begin
                if (tx_ok) begin
                    tx_write_nxt = 1'b1;
                    tx_data_nxt  = nak ? RSP_NAK : (is_write ? RSP_ACK : rdata_byte);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench: byte-level UART model plus a one-wait-state RAM behind the bus.
module tb_uart_bus_master;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        rx_read;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        tx_write;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        cpu_hold;

    int checks = 0;
    int errors = 0;

    logic [7:0]  rx_q[$];
    logic [7:0]  tx_q[$];
    logic        ram_en;
    logic [31:0] ram [0:63];
    int          valid_cycles = 0;
    int          bus_count = 0;
    logic [31:0] last_addr = '0;
    logic [31:0] last_wdata = '0;
    logic [3:0]  last_wstrb = '0;

    always #5 clk = ~clk;

    uart_bus_master #(.TIMEOUT_CYCLES(32'd50), .BUS_WAIT_MAX(16'd8)) dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_ready(rx_ready), .rx_read(rx_read),
        .tx_data(tx_data), .tx_ready(tx_ready), .tx_write(tx_write),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .cpu_hold(cpu_hold)
    );

    // uart_rx side: pop on rx_read, present the head byte from the next edge
    always @(posedge clk) begin
        if (rx_read && rx_q.size() > 0) void'(rx_q.pop_front());
        rx_ready <= (rx_q.size() != 0);
        rx_data  <= (rx_q.size() != 0) ? rx_q[0] : 8'h00;
    end

    always @(posedge clk) begin
        if (tx_write) tx_q.push_back(tx_data);
    end

    // RAM with one wait state
    always @(posedge clk) begin
        mem_ready <= mem_valid && ram_en;
        mem_rdata <= ram[mem_addr[7:2]];
        if (mem_valid) valid_cycles <= valid_cycles + 1;
        if (mem_valid && mem_ready) begin
            bus_count  <= bus_count + 1;
            last_addr  <= mem_addr;
            last_wdata <= mem_wdata;
            last_wstrb <= mem_wstrb;
            if (mem_wstrb == 4'hF) ram[mem_addr[7:2]] <= mem_wdata;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_tx(input int n, input int budget, input string name);
        int c = 0;
        while (tx_q.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (tx_q.size() < n) begin
            errors++;
            $display("FAIL %s: got %0d tx bytes, required %0d", name, tx_q.size(), n);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tx_ready = 1'b1;
        ram_en = 1'b1;
        tick(3);
        checks++;
        if ({rx_read, tx_write, mem_valid, cpu_hold} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, required 0000", {rx_read, tx_write, mem_valid, cpu_hold});
        end
        checks++;
        if (tx_data !== 8'h00 || mem_wstrb !== 4'h0) begin
            errors++;
            $display("FAIL reset_data: tx_data %h wstrb %h, required 00 0", tx_data, mem_wstrb);
        end
        checks++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus: addr %h wdata %h, required 0 0", mem_addr, mem_wdata);
        end
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_write;
        int b0 = bus_count;
        tx_q.delete();
        rx_q.push_back(8'h57);
        rx_q.push_back(8'h10); rx_q.push_back(8'h00); rx_q.push_back(8'h00); rx_q.push_back(8'h00);
        rx_q.push_back(8'hEF); rx_q.push_back(8'hBE); rx_q.push_back(8'hAD); rx_q.push_back(8'hDE);
        wait_tx(1, 300, "write_reply");
        tick(2);
        checks++;
        if (bus_count - b0 !== 1) begin
            errors++;
            $display("FAIL write_count: got %0d transfers, required 1", bus_count - b0);
        end
        checks++;
        if (last_addr !== 32'h10 || last_wdata !== 32'hDEADBEEF || last_wstrb !== 4'hF) begin
            errors++;
            $display("FAIL write_xfer: got %h/%h/%h, required 00000010/deadbeef/f", last_addr, last_wdata, last_wstrb);
        end
        checks++;
        if (tx_q.size() != 1 || tx_q[0] !== 8'h06) begin
            errors++;
            $display("FAIL write_ack: got %0d bytes first %h, required 1 byte 06", tx_q.size(), tx_q[0]);
        end
        checks++;
        if (cpu_hold !== 1'b0) begin
            errors++;
            $display("FAIL write_hold: got %b, required 0", cpu_hold);
        end
    endtask

    task automatic test_read;
        int b0 = bus_count;
        logic [7:0] exp [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        tx_q.delete();
        rx_q.push_back(8'h52);
        rx_q.push_back(8'h10); rx_q.push_back(8'h00); rx_q.push_back(8'h00); rx_q.push_back(8'h00);
        wait_tx(4, 300, "read_reply");
        tick(2);
        checks++;
        if (bus_count - b0 !== 1 || last_addr !== 32'h10 || last_wstrb !== 4'h0) begin
            errors++;
            $display("FAIL read_xfer: got %0d xfers addr %h wstrb %h, required 1 00000010 0", bus_count - b0, last_addr, last_wstrb);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (tx_q[i] !== exp[i]) begin
                errors++;
                $display("FAIL read_byte%0d: got %h, required %h", i, tx_q[i], exp[i]);
            end
        end
    endtask

    task automatic test_nak;
        int v0 = valid_cycles;
        tx_q.delete();
        rx_q.push_back(8'h41);
        wait_tx(1, 100, "nak_reply");
        tick(2);
        checks++;
        if (tx_q[0] !== 8'h15) begin
            errors++;
            $display("FAIL nak_byte: got %h, required 15", tx_q[0]);
        end
        checks++;
        if (valid_cycles - v0 !== 0) begin
            errors++;
            $display("FAIL nak_bus: got %0d mem_valid cycles, required 0", valid_cycles - v0);
        end
        checks++;
        if (cpu_hold !== 1'b0) begin
            errors++;
            $display("FAIL nak_hold: got %b, required 0", cpu_hold);
        end
    endtask

    task automatic test_tx_stall;
        logic [7:0] exp [5] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h15};
        tx_q.delete();
        tx_ready = 1'b0;
        rx_q.push_back(8'h52);
        rx_q.push_back(8'h13); rx_q.push_back(8'h00); rx_q.push_back(8'h00); rx_q.push_back(8'h00);
        tick(40);
        rx_q.push_back(8'h41);
        tick(60);
        checks++;
        if (last_addr !== 32'h10 || mem_addr !== 32'h10) begin
            errors++;
            $display("FAIL stall_addr: got %h / %h, required 00000010", last_addr, mem_addr);
        end
        checks++;
        if (tx_q.size() != 0 || cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold: got %0d tx bytes hold %b, required 0 and 1", tx_q.size(), cpu_hold);
        end
        checks++;
        if (rx_q.size() != 1) begin
            errors++;
            $display("FAIL stall_rx: got %0d queued rx bytes, required 1", rx_q.size());
        end
        tx_ready = 1'b1;
        wait_tx(5, 300, "stall_reply");
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (tx_q[i] !== exp[i]) begin
                errors++;
                $display("FAIL stall_byte%0d: got %h, required %h", i, tx_q[i], exp[i]);
            end
        end
    endtask

    task automatic test_timeout;
        int v0 = valid_cycles;
        int c = 0;
        tick(5);
        tx_q.delete();
        rx_q.push_back(8'h57); rx_q.push_back(8'h10); rx_q.push_back(8'h00);
        while (rx_q.size() != 0 && c < 100) begin
            @(negedge clk);
            c++;
        end
        tick(40);
        checks++;
        if (cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early: got hold %b, required 1", cpu_hold);
        end
        tick(20);
        checks++;
        if (cpu_hold !== 1'b0 || tx_q.size() != 0 || valid_cycles - v0 != 0) begin
            errors++;
            $display("FAIL timeout_abort: got hold %b tx %0d valid %0d, required 0 0 0", cpu_hold, tx_q.size(), valid_cycles - v0);
        end
        rx_q.push_back(8'h41);
        wait_tx(1, 100, "timeout_idle");
        checks++;
        if (tx_q[0] !== 8'h15) begin
            errors++;
            $display("FAIL timeout_idle_byte: got %h, required 15", tx_q[0]);
        end
    endtask

    task automatic test_bus_timeout;
        int v0 = valid_cycles;
        int b0 = bus_count;
        tick(5);
        tx_q.delete();
        ram_en = 1'b0;
        rx_q.push_back(8'h52);
        rx_q.push_back(8'h20); rx_q.push_back(8'h00); rx_q.push_back(8'h00); rx_q.push_back(8'h00);
        wait_tx(1, 300, "bus_to_reply");
        tick(2);
        checks++;
        if (valid_cycles - v0 !== 8 || bus_count - b0 !== 0) begin
            errors++;
            $display("FAIL bus_to_valid: got %0d valid cycles %0d xfers, required 8 0", valid_cycles - v0, bus_count - b0);
        end
        checks++;
        if (tx_q[0] !== 8'h15 || mem_valid !== 1'b0 || cpu_hold !== 1'b0) begin
            errors++;
            $display("FAIL bus_to_nak: got %h valid %b hold %b, required 15 0 0", tx_q[0], mem_valid, cpu_hold);
        end
    endtask

    task automatic test_reset_mid_bus;
        int c = 0;
        tx_q.delete();
        rx_q.push_back(8'h52);
        rx_q.push_back(8'h10); rx_q.push_back(8'h00); rx_q.push_back(8'h00); rx_q.push_back(8'h00);
        while (mem_valid !== 1'b1 && c < 100) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (mem_valid !== 1'b1) begin
            errors++;
            $display("FAIL midbus_start: got mem_valid %b, required 1", mem_valid);
        end
        tick(2);
        reset = 1'b1;
        tick(1);
        checks++;
        if ({mem_valid, cpu_hold, rx_read, tx_write} !== 4'b0000 || mem_wstrb !== 4'h0 || mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL midbus_reset: got ctrl %b wstrb %h addr %h, required 0000 0 0",
                     {mem_valid, cpu_hold, rx_read, tx_write}, mem_wstrb, mem_addr);
        end
        reset = 1'b0;
        ram_en = 1'b1;
        tick(2);
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp [8] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        tx_q.delete();
        for (int k = 0; k < 2; k++) begin
            rx_q.push_back(8'h52);
            rx_q.push_back(8'h11); rx_q.push_back(8'h00); rx_q.push_back(8'h00); rx_q.push_back(8'h00);
        end
        wait_tx(8, 400, "b2b_reply");
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (tx_q[i] !== exp[i]) begin
                errors++;
                $display("FAIL b2b_byte%0d: got %h, required %h", i, tx_q[i], exp[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_nak();
        test_tx_stall();
        test_timeout();
        test_bus_timeout();
        test_reset_mid_bus();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
